// File: rtl/mul_seq_param_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_seq_param_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_seq_param_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface mul_seq_param_if #(
   parameter int W = 8
);
   logic           start;
   logic [W-1:0]   a_i;
   logic [W-1:0]   b_i;
   logic [2*W-1:0] p_o;
   logic           busy;
   logic           done;

   modport master (output start, a_i, b_i, input p_o, busy, done);
   modport slave  (input start, a_i, b_i, output p_o, busy, done);
endinterface

// File: rtl/mul_seq_param.sv
// Radix-2 shift-add multiplier producing one product bit per clock (W cycles/product).
// Define MUL_SIGNED_EN for two's-complement operands and product.
module mul_seq_param
   import mul_seq_param_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   mul_seq_param_if.slave mul_if
);
   localparam int CNT_W = clog2(W + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [2*W-1:0]   p_q, p_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W:0]       sum_s;
   logic [2*W-1:0]   acc_step_s;
   logic [2*W-1:0]   result_s;
   logic [W-1:0]     a_mag_s;
   logic [W-1:0]     b_mag_s;

`ifdef MUL_SIGNED_EN
   logic sign_q, sign_d;

   // Magnitudes: -2^(W-1) maps to 2^(W-1), which still fits in W unsigned bits.
   always_comb begin
      a_mag_s = mul_if.a_i[W-1] ? ((~mul_if.a_i) + W'(1)) : mul_if.a_i;
      b_mag_s = mul_if.b_i[W-1] ? ((~mul_if.b_i) + W'(1)) : mul_if.b_i;
   end

   assign result_s = sign_q ? ((~acc_step_s) + (2*W)'(1)) : acc_step_s;

   // Sign of the product in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_q <= 1'b0;
      end else begin
         sign_q <= sign_d;
      end
   end
`else
   assign a_mag_s  = mul_if.a_i;
   assign b_mag_s  = mul_if.b_i;
   assign result_s = acc_step_s;
`endif

   // One iteration: conditional add into the upper half with carry, then shift right.
   always_comb begin
      sum_s      = {1'b0, acc_q[2*W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
      acc_step_s = {sum_s, acc_q[W-1:1]};
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      p_d      = p_q;
`ifdef MUL_SIGNED_EN
      sign_d   = sign_q;
`endif
      case (state_q)
         ST_RUN: begin
            acc_d    = acc_step_s;
            mplier_d = {1'b0, mplier_q[W-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(W)) begin
               state_d = ST_DONE;
               p_d     = result_s;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_IDLE, ST_DONE: begin
            if (mul_if.start) begin
               state_d  = ST_RUN;
               cnt_d    = '0;
               mcand_d  = a_mag_s;
               mplier_d = b_mag_s;
               acc_d    = '0;
`ifdef MUL_SIGNED_EN
               sign_d   = mul_if.a_i[W-1] ^ mul_if.b_i[W-1];
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         p_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         p_q      <= p_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign mul_if.p_o  = p_q;
   assign mul_if.busy = busy_q;
   assign mul_if.done = done_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Scoreboard bench for mul_seq_param at W=8 (directed + random) and W=16 (random, held start).
`timescale 1ns/1ps
module tb_mul_seq_param;

   typedef struct {
      longint p;
      int     cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   pass_cnt;
   int   total_cnt;
   exp_t exp8_q[$];
   exp_t exp16_q[$];
   int   done8_last;
   int   done8_before;

   mul_seq_param_if #(.W(8))  if8 ();
   mul_seq_param_if #(.W(16)) if16 ();

   mul_seq_param #(.W(8))  dut8  (.clk(clk), .rst(rst), .mul_if(if8));
   mul_seq_param #(.W(16)) dut16 (.clk(clk), .rst(rst), .mul_if(if16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the mathematical product of the operands, reduced to 2w bits.
   function automatic longint ref_prod(input longint a, input longint b, input int w);
      longint sa;
      longint sb;
      sa = a;
      sb = b;
`ifdef MUL_SIGNED_EN
      if (a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
      if (b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
`endif
      return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      total_cnt++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b);
      int   n;
      exp_t e;
      n = 0;
      while (if8.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (if8.busy) begin
         fail_now("issue8_wait");
      end else begin
         if8.a_i   = a;
         if8.b_i   = b;
         if8.start = 1'b1;
         e.p   = ref_prod(longint'(a), longint'(b), 8);
         e.cyc = cyc + 1 + 8;
         exp8_q.push_back(e);
         @(negedge clk);
         if8.start = 1'b0;
      end
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b);
      int   n;
      exp_t e;
      n = 0;
      while (if16.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (if16.busy) begin
         fail_now("issue16_wait");
      end else begin
         if16.a_i   = a;
         if16.b_i   = b;
         if16.start = 1'b1;
         e.p   = ref_prod(longint'(a), longint'(b), 16);
         e.cyc = cyc + 1 + 16;
         exp16_q.push_back(e);
         @(negedge clk);
         if16.start = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp8_q.size() != 0 || exp16_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (exp8_q.size() != 0 || exp16_q.size() != 0) fail_now("drain");
   endtask

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         default: return 16'($urandom);
      endcase
   endfunction

   // Monitor for the W=8 instance: pops expectations on each done pulse.
   initial begin : mon8
      int   busy_cnt;
      logic done_prev;
      exp_t e;
      busy_cnt   = 0;
      done_prev  = 1'b0;
      done8_last = 0;
      done8_before = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
         end else begin
            if (if8.busy) busy_cnt++;
            if (if8.done) begin
               chk("done8_pulse", longint'(done_prev), 0);
               if (exp8_q.size() == 0) begin
                  fail_now("done8_unexpected");
               end else begin
                  e = exp8_q.pop_front();
                  chk("p8", longint'(if8.p_o), e.p);
                  chk("lat8", longint'(cyc), longint'(e.cyc));
                  chk("busy8_len", longint'(busy_cnt), 8);
               end
               busy_cnt     = 0;
               done8_before = done8_last;
               done8_last   = cyc;
            end
            done_prev = if8.done;
         end
      end
   end

   // Monitor for the W=16 instance.
   initial begin : mon16
      int   busy_cnt;
      logic done_prev;
      exp_t e;
      busy_cnt  = 0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
         end else begin
            if (if16.busy) busy_cnt++;
            if (if16.done) begin
               chk("done16_pulse", longint'(done_prev), 0);
               if (exp16_q.size() == 0) begin
                  fail_now("done16_unexpected");
               end else begin
                  e = exp16_q.pop_front();
                  chk("p16", longint'(if16.p_o), e.p);
                  chk("lat16", longint'(cyc), longint'(e.cyc));
                  chk("busy16_len", longint'(busy_cnt), 16);
               end
               busy_cnt = 0;
            end
            done_prev = if16.done;
         end
      end
   end

   initial begin : stim
      int   c;
      exp_t e;
      pass_cnt   = 0;
      total_cnt  = 0;
      rst        = 1'b1;
      if8.start  = 1'b0;
      if8.a_i    = 8'h00;
      if8.b_i    = 8'h00;
      if16.start = 1'b0;
      if16.a_i   = 16'h0000;
      if16.b_i   = 16'h0000;

      @(negedge clk);
      chk("rst_p8", longint'(if8.p_o), 0);
      chk("rst_busy8", longint'(if8.busy), 0);
      chk("rst_done8", longint'(if8.done), 0);
      chk("rst_p16", longint'(if16.p_o), 0);
      chk("rst_busy16", longint'(if16.busy), 0);
      chk("rst_done16", longint'(if16.done), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a product.
      issue8(8'd5, 8'd5);
      drain();
      issue8(8'd7, 8'd7);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_p8", longint'(if8.p_o), 0);
      chk("midrst_busy8", longint'(if8.busy), 0);
      chk("midrst_done8", longint'(if8.done), 0);
      exp8_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue8(8'd3, 8'd4);
      drain();

      // Extreme and zero operands.
      issue8(8'hFF, 8'hFF);
      issue8(8'h00, 8'h55);
      drain();

      // Back-to-back: second start lands in the done cycle of the first.
      issue8(8'd5, 8'd6);
      issue8(8'd200, 8'd2);
      drain();
      chk("b2b_gap8", longint'(done8_last - done8_before), 9);

      // Start during busy is ignored and p_o holds the previous result.
      issue8(8'd7, 8'd9);
      chk("hold_p8", longint'(if8.p_o), ref_prod(200, 2, 8));
      repeat (3) @(negedge clk);
      if8.a_i   = 8'd1;
      if8.b_i   = 8'd1;
      if8.start = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      drain();

`ifdef MUL_SIGNED_EN
      issue8(8'h80, 8'h80);
      issue8(8'hFD, 8'h07);
      issue8(8'hFF, 8'hFF);
      drain();
`endif

      for (int i = 0; i < 200; i++) begin
         issue8(8'($urandom), 8'($urandom));
      end
      drain();

      // Held start on W=16: restarts every W+1 cycles.
      c = cyc;
      if16.a_i   = 16'h8001;
      if16.b_i   = 16'hFFFE;
      if16.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e.p   = ref_prod(longint'(16'h8001), longint'(16'hFFFE), 16);
         e.cyc = c + 1 + 16 + i * 17;
         exp16_q.push_back(e);
      end
      repeat (35) @(negedge clk);
      if16.start = 1'b0;
      drain();

      for (int i = 0; i < 1500; i++) begin
         issue16(rnd16(), rnd16());
      end
      drain();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
